regfile_dump_uart: RTL
======================

Name: regfile_dump_uart

Overview:
Debug readout engine for the register file's debug read port. On a start pulse it reads x0..x31 one at a time through the debug address/strobe/data interface. It serialises a header byte followed by every 32-bit register value onto a UART 8N1 transmit line. It sits beside the pipeline and register file, clocked by the core clock, and drives the register file's debug address and debug clock inputs.

Parameters:
CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200); legal range >= 2
HEADER, 8'hA5, frame header byte sent before register data

Ports:
clock  input  1  core clock, all state updates on posedge
reset  input  1  asynchronous, active-low reset; 0 forces the reset state immediately
start  input  1  dump request, sampled on posedge; ignored while busy=1
dbg_addr  output  5  debug read address to register file
dbg_clk  output  1  debug read strobe to register file; registered, one-cycle high pulse
dbg_data  input  32  debug read data from register file
tx  output  1  UART serial out, idle high
busy  output  1  high while a dump is in progress
done  output  1  one-cycle pulse when the final stop bit completes

Behaviour:
- Reset (reset=0, asynchronous): tx=1, busy=0, done=0, dbg_clk=0, dbg_addr=0, FSM=IDLE, index=0. Any partial byte is abandoned and not resumed.
- IDLE: tx=1, busy=0. At a posedge with start=1, load HEADER into the shift register, drive tx<=0 (start bit), set busy<=1, and enter SEND.
- SEND (UART bit engine):
  - Start bit: 0 for CLKS_PER_BIT cycles.
  - Data bits: 8 bits LSB first, each held for CLKS_PER_BIT cycles.
  - Stop bit: 1 for CLKS_PER_BIT cycles.
  - One byte lasts exactly 10*CLKS_PER_BIT cycles.
  - Consecutive bytes of the same word are back to back: the next start bit begins on the cycle after the stop bit ends.
- After the header stop bit, enter RD_ADDR with index=0.
- RD_ADDR (1 cycle): dbg_addr<=index, tx=1.
- RD_STROBE (1 cycle): dbg_clk=1.
- RD_CAP (1 cycle): dbg_clk=0; the word register captures dbg_data at the posedge ending this cycle.
- After RD_CAP, send the 4 word bytes MSB first (bits 31:24, 23:16, 15:8, 7:0), then:
  - index<31: index<=index+1, go to RD_ADDR.
  - index=31: at the edge ending the last stop bit, busy<=0, done<=1 for exactly one cycle, go to IDLE.
- tx stays 1 during the 3 read cycles between words.
- dbg_addr holds its last value outside RD_ADDR. dbg_clk is high only in RD_STROBE.
- Frame length: 129 bytes. busy high for exactly 10*C + 32*(3 + 40*C) cycles, where C = CLKS_PER_BIT.
- start=1 while busy is ignored and not queued. start held high through done restarts a new dump on the first IDLE cycle.
- Register writes during a dump are not blocked. Each word reflects the register value at its own capture edge; the dump is not an atomic snapshot.
- x0 is read like any other register; its value is whatever dbg_data returns.
- The bit counter, byte counter and 5-bit index never wrap mid-frame. Index 31 terminates the frame; it is never incremented.

Test Plan:
- Reset check: CLKS_PER_BIT=4, reset=0 mid-header bit 3 -> tx=1, busy=0, dbg_clk=0, dbg_addr=0 immediately without waiting for a clock. After release, line stays idle until start.
- Header framing: CLKS_PER_BIT=4, one-cycle start pulse -> tx sequence 0,1,0,1,0,0,1,0,1,1 (start bit, 0xA5 LSB first, stop bit), each level exactly 4 cycles.
- Register readout: model regfile with reg[i]=32'h1000_0000+i -> decoded UART bytes: A5, then 10 00 00 00, 10 00 00 01, ..., 10 00 00 1F. dbg_clk pulses exactly 32 times, each one cycle wide, with dbg_addr = 0..31 in order.
- Timing/done: CLKS_PER_BIT=4 -> busy high for exactly 5256 cycles; done high exactly 1 cycle, coincident with busy falling; tx=1 afterwards.
- Start while busy: pulse start at cycles 100 and 3000 of a dump -> only one 129-byte frame. Holding start high continuously produces two contiguous frames separated by one IDLE cycle.
- Concurrent write: change reg[5] from 5 to 32'hDEADBEEF after its capture edge but before reg[6] capture -> frame shows 00 00 00 05 for reg 5. A write to reg[6] before its capture shows the new value.

Source files
------------

// File: rtl/regfile_dump_uart.sv
// Debug readout engine: reads x0..x31 over the register file debug port and
// streams a header byte plus each word (MSB byte first) out as UART 8N1.
module regfile_dump_uart #(
  parameter int         CLKS_PER_BIT = 434,
  parameter logic [7:0] HEADER       = 8'hA5
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic [4:0]  dbg_addr,
  output logic        dbg_clk,
  input  logic [31:0] dbg_data,
  output logic        tx,
  output logic        busy,
  output logic        done
);

  localparam int               CNT_W   = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    RD_ADDR,
    RD_STROBE,
    RD_CAP
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] clk_cnt;
  logic [3:0]       bit_cnt;
  logic [1:0]       byte_cnt;
  logic [4:0]       index;
  logic             in_hdr;
  logic [7:0]       tx_byte;
  logic [31:0]      word;
  logic             bit_end;
  logic             byte_end;
  logic             word_end;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    bit_end   = (state == SEND) && (clk_cnt == CNT_MAX);
    byte_end  = bit_end && (bit_cnt == 4'd9);
    word_end  = byte_end && !in_hdr && (byte_cnt == 2'd3);
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = SEND;
        end
      end
      SEND: begin
        if (byte_end && in_hdr) begin
          state_nxt = RD_ADDR;
        end else if (word_end) begin
          state_nxt = (index == 5'd31) ? IDLE : RD_ADDR;
        end
      end
      RD_ADDR:   state_nxt = RD_STROBE;
      RD_STROBE: state_nxt = RD_CAP;
      RD_CAP:    state_nxt = SEND;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tx       <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      dbg_clk  <= 1'b0;
      dbg_addr <= 5'd0;
      index    <= 5'd0;
      clk_cnt  <= '0;
      bit_cnt  <= 4'd0;
      byte_cnt <= 2'd0;
      in_hdr   <= 1'b0;
      tx_byte  <= 8'd0;
      word     <= 32'd0;
    end else begin
      done    <= 1'b0;
      dbg_clk <= (state == RD_ADDR);
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (start) begin
            tx_byte  <= HEADER;
            tx       <= 1'b0;
            busy     <= 1'b1;
            in_hdr   <= 1'b1;
            index    <= 5'd0;
            clk_cnt  <= '0;
            bit_cnt  <= 4'd0;
            byte_cnt <= 2'd0;
          end
        end
        SEND: begin
          if (!bit_end) begin
            clk_cnt <= clk_cnt + 1'b1;
          end else begin
            clk_cnt <= '0;
            if (bit_cnt != 4'd9) begin
              // bit_cnt is the bit just finished; drive the following one
              bit_cnt <= bit_cnt + 4'd1;
              tx      <= (bit_cnt == 4'd8) ? 1'b1 : tx_byte[bit_cnt[2:0]];
            end else begin
              bit_cnt <= 4'd0;
              if (in_hdr) begin
                in_hdr   <= 1'b0;
                index    <= 5'd0;
                dbg_addr <= 5'd0;
              end else if (byte_cnt != 2'd3) begin
                byte_cnt <= byte_cnt + 2'd1;
                tx_byte  <= word[23:16];
                word     <= {word[23:0], 8'h00};
                tx       <= 1'b0;
              end else if (index == 5'd31) begin
                busy <= 1'b0;
                done <= 1'b1;
              end else begin
                byte_cnt <= 2'd0;
                index    <= index + 5'd1;
                dbg_addr <= index + 5'd1;
              end
            end
          end
        end
        RD_CAP: begin
          word     <= dbg_data;
          tx_byte  <= dbg_data[31:24];
          tx       <= 1'b0;
          clk_cnt  <= '0;
          bit_cnt  <= 4'd0;
          byte_cnt <= 2'd0;
        end
        default: begin
        end
      endcase
    end
  end

endmodule
